neural_pio_mailbox: RTL and testbench
=====================================

NEURAL_PIO_MAILBOX -- requirements
Module: neural_pio_mailbox

Interface
REQ-001 Parameter: DATA_W, default 32, word width of both directions.
REQ-002 Parameter: DEPTH, default 8, entries per FIFO; power of two, 2..256.
REQ-003 clk_clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-005 sw_wdata  in  DATA_W  word from software PIO, destined for hardware.
REQ-006 to_sw_sig  in  2  software request: bit0=write req, bit1=read req.
REQ-007 to_hw_sig  out  2  block acknowledge: bit0=write ack, bit1=read ack.
REQ-008 sw_rdata  out  DATA_W  word returned to software PIO.
REQ-009 hw_in_data  out  DATA_W  head of TX FIFO toward accelerator.
REQ-010 hw_in_valid  out  1  / hw_in_ready  in  1  TX stream handshake.
REQ-011 hw_out_data  in  DATA_W  result word from accelerator.
REQ-012 hw_out_valid  in  1  / hw_out_ready  out  1  RX stream handshake.
REQ-013 tx_level, rx_level  out  $clog2(DEPTH)+1 each; stall_cnt  out  16 (present only per REQ-030).

Function
REQ-014 TX FIFO (SW->HW) and RX FIFO (HW->SW) SHALL each hold DEPTH words, first-word-fall-through, wrap-around pointers.
REQ-015 Write FSM states W_IDLE, W_ACK; in W_IDLE with to_sw_sig[0]=1 and TX not full: push sw_wdata, set to_hw_sig[0]=1 next cycle, go W_ACK.
REQ-016 W_IDLE with to_sw_sig[0]=1 and TX full: no push, ack stays 0, remain W_IDLE until space.
REQ-017 W_ACK: when to_sw_sig[0]=0, clear to_hw_sig[0] next cycle, go W_IDLE; exactly one push per 4-phase handshake.
REQ-018 Read FSM states R_IDLE, R_ACK; in R_IDLE with to_sw_sig[1]=1 and RX not empty: register RX head into sw_rdata, pop, set to_hw_sig[1]=1 next cycle, go R_ACK.
REQ-019 R_IDLE with to_sw_sig[1]=1 and RX empty: wait, no ack.
REQ-020 R_ACK: when to_sw_sig[1]=0, clear to_hw_sig[1], go R_IDLE; sw_rdata holds until next read.
REQ-021 hw_in_valid = TX not empty; hw_in_data = TX head; pop on hw_in_valid & hw_in_ready.
REQ-022 hw_out_ready = RX not full; push on hw_out_valid & hw_out_ready.
REQ-023 Simultaneous push and pop on one FIFO SHALL both occur; level unchanged.
REQ-024 Full/empty decisions SHALL use registered levels; push into a full FIFO is blocked even with a same-cycle pop.
REQ-025 Write and read FSMs independent; both may handshake in the same cycle.

Reset
REQ-026 Reset asserted SHALL asynchronously clear both FIFOs (levels 0), FSMs to W_IDLE/R_IDLE, to_hw_sig=0, sw_rdata=0, hw_in_valid=0.
REQ-027 hw_out_ready SHALL be 0 during reset, 1 from the first cycle after release.
REQ-028 Reset mid-handshake SHALL discard in-flight words; software restarts the handshake from req low.
REQ-029 stall_cnt resets to 0.

Configuration
REQ-030 Macro NEURAL_MBOX_STATUS_EN defined: tx_level, rx_level, stall_cnt ports exist; stall_cnt increments (saturating at 65535) each cycle REQ-016 wait holds.
REQ-031 NEURAL_MBOX_STATUS_EN undefined: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 Write 0xDEADBEEF via 4-phase with hw_in_ready=1 -> to_hw_sig[0] rises 1 cycle after req; hw_in_valid with hw_in_data=0xDEADBEEF next cycle.
REQ-033 hw_in_ready=0, 9 writes at DEPTH=8 -> 8 acked, 9th ack held low, tx_level=8, stall_cnt increments; raise hw_in_ready -> 9th acked.
REQ-034 hw_out pushes 1,2,3 then 3 SW reads -> sw_rdata 1,2,3 in order, rx_level 0, further read req gets no ack.
REQ-035 SW write and HW pop same cycle with TX level 4 -> tx_level stays 4.
REQ-036 Reset pulse while to_hw_sig[0]=1 and TX level 3 -> to_hw_sig=0, levels 0, hw_in_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/neural_pio_mailbox.sv
// Two-FIFO mailbox linking a 4-phase software PIO handshake to valid/ready accelerator streams.
// Define NEURAL_MBOX_STATUS_EN to expose tx_level, rx_level and the saturating stall_cnt.
module neural_pio_mailbox #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] sw_wdata,
    input  logic [1:0]        to_sw_sig,
    output logic [1:0]        to_hw_sig,
    output logic [DATA_W-1:0] sw_rdata,
    output logic [DATA_W-1:0] hw_in_data,
    output logic              hw_in_valid,
    input  logic              hw_in_ready,
    input  logic [DATA_W-1:0] hw_out_data,
    input  logic              hw_out_valid,
    output logic              hw_out_ready
`ifdef NEURAL_MBOX_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0] tx_level,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {W_IDLE, W_ACK} wstate_t;
    typedef enum logic {R_IDLE, R_ACK} rstate_t;

    logic [DATA_W-1:0] tx_mem_q [DEPTH];
    logic [DATA_W-1:0] rx_mem_q [DEPTH];

    logic [PTR_W-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [PTR_W-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [LVL_W-1:0]  tx_level_q, tx_level_d, rx_level_q, rx_level_d;
    wstate_t           wstate_q, wstate_d;
    rstate_t           rstate_q, rstate_d;
    logic              wack_q, wack_d, rack_q, rack_d;
    logic [DATA_W-1:0] sw_rdata_q, sw_rdata_d;
    logic              rdy_en_q;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;

    // Full/empty come from registered levels only, so a same-cycle pop never frees room for a push.
    assign tx_full  = (tx_level_q == FULL_LVL);
    assign tx_empty = (tx_level_q == '0);
    assign rx_full  = (rx_level_q == FULL_LVL);
    assign rx_empty = (rx_level_q == '0);

    assign tx_pop       = !tx_empty && hw_in_ready;
    assign hw_out_ready = rdy_en_q && !rx_full;
    assign rx_push      = hw_out_valid && hw_out_ready;

    assign hw_in_valid = !tx_empty;
    assign hw_in_data  = tx_mem_q[tx_rptr_q];
    assign to_hw_sig   = {rack_q, wack_q};
    assign sw_rdata    = sw_rdata_q;

    always_comb begin
        wstate_d = wstate_q;
        wack_d   = wack_q;
        tx_push  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (to_sw_sig[0] && !tx_full) begin
                    tx_push  = 1'b1;
                    wack_d   = 1'b1;
                    wstate_d = W_ACK;
                end
            end
            W_ACK: begin
                if (!to_sw_sig[0]) begin
                    wack_d   = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d   = rstate_q;
        rack_d     = rack_q;
        sw_rdata_d = sw_rdata_q;
        rx_pop     = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (to_sw_sig[1] && !rx_empty) begin
                    rx_pop     = 1'b1;
                    sw_rdata_d = rx_mem_q[rx_rptr_q];
                    rack_d     = 1'b1;
                    rstate_d   = R_ACK;
                end
            end
            R_ACK: begin
                if (!to_sw_sig[1]) begin
                    rack_d   = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_wptr_d  = tx_push ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d  = tx_pop  ? tx_rptr_q + 1'b1 : tx_rptr_q;
        rx_wptr_d  = rx_push ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d  = rx_pop  ? rx_rptr_q + 1'b1 : rx_rptr_q;
        tx_level_d = tx_level_q;
        rx_level_d = rx_level_q;
        if (tx_push && !tx_pop) begin
            tx_level_d = tx_level_q + 1'b1;
        end else if (!tx_push && tx_pop) begin
            tx_level_d = tx_level_q - 1'b1;
        end
        if (rx_push && !rx_pop) begin
            rx_level_d = rx_level_q + 1'b1;
        end else if (!rx_push && rx_pop) begin
            rx_level_d = rx_level_q - 1'b1;
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers and levels.
    always_ff @(posedge clk_clk) begin
        if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= sw_wdata;
        end
        if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= hw_out_data;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_level_q <= '0;
            rx_level_q <= '0;
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            wack_q     <= 1'b0;
            rack_q     <= 1'b0;
            sw_rdata_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_level_q <= tx_level_d;
            rx_level_q <= rx_level_d;
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            wack_q     <= wack_d;
            rack_q     <= rack_d;
            sw_rdata_q <= sw_rdata_d;
            rdy_en_q   <= 1'b1;
        end
    end

`ifdef NEURAL_MBOX_STATUS_EN
    logic        wr_stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where software is requesting a write but the TX FIFO has no room.
    assign wr_stall = (wstate_q == W_IDLE) && to_sw_sig[0] && tx_full;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wr_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign tx_level  = tx_level_q;
    assign rx_level  = rx_level_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_neural_pio_mailbox.sv
// Self-checking bench for neural_pio_mailbox: directed scenarios plus random traffic scored
// against a queue-based model of the two mailboxes and their software handshakes.
module tb_neural_pio_mailbox;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic              clk_clk;
    logic              reset_reset_n;
    logic [DATA_W-1:0] sw_wdata;
    logic [1:0]        to_sw_sig;
    logic [1:0]        to_hw_sig;
    logic [DATA_W-1:0] sw_rdata;
    logic [DATA_W-1:0] hw_in_data;
    logic              hw_in_valid;
    logic              hw_in_ready;
    logic [DATA_W-1:0] hw_out_data;
    logic              hw_out_valid;
    logic              hw_out_ready;
`ifdef NEURAL_MBOX_STATUS_EN
    logic [$clog2(DEPTH):0] tx_level;
    logic [$clog2(DEPTH):0] rx_level;
    logic [15:0]            stall_cnt;
`endif

    neural_pio_mailbox #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .sw_wdata      (sw_wdata),
        .to_sw_sig     (to_sw_sig),
        .to_hw_sig     (to_hw_sig),
        .sw_rdata      (sw_rdata),
        .hw_in_data    (hw_in_data),
        .hw_in_valid   (hw_in_valid),
        .hw_in_ready   (hw_in_ready),
        .hw_out_data   (hw_out_data),
        .hw_out_valid  (hw_out_valid),
        .hw_out_ready  (hw_out_ready)
`ifdef NEURAL_MBOX_STATUS_EN
        ,
        .tx_level      (tx_level),
        .rx_level      (rx_level),
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents of each FIFO, whether a handshake is awaiting req release.
    logic [DATA_W-1:0] txq[$];
    logic [DATA_W-1:0] rxq[$];
    bit                w_busy;
    bit                r_busy;
    bit                rdy_en;
    logic [DATA_W-1:0] m_rdata;
    int                m_stall;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("to_hw_sig", 64'(to_hw_sig), 64'({r_busy, w_busy}));
        checkVal("sw_rdata", 64'(sw_rdata), 64'(m_rdata));
        checkVal("hw_in_valid", 64'(hw_in_valid), 64'(txq.size() != 0));
        if (txq.size() != 0) begin
            checkVal("hw_in_data", 64'(hw_in_data), 64'(txq[0]));
        end
        checkVal("hw_out_ready", 64'(hw_out_ready), 64'(rdy_en && (rxq.size() < DEPTH)));
`ifdef NEURAL_MBOX_STATUS_EN
        checkVal("tx_level", 64'(tx_level), 64'(txq.size()));
        checkVal("rx_level", 64'(rx_level), 64'(rxq.size()));
        checkVal("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    endtask

    task automatic applyStimulus(input logic [1:0] req, input logic [DATA_W-1:0] wdata,
                                 input logic in_rdy, input logic out_vld,
                                 input logic [DATA_W-1:0] out_data);
        to_sw_sig    = req;
        sw_wdata     = wdata;
        hw_in_ready  = in_rdy;
        hw_out_valid = out_vld;
        hw_out_data  = out_data;
    endtask

    // One clock: decide the transfers from pre-edge inputs and model occupancy, then check.
    task automatic cycle();
        int tx_n, rx_n;
        bit pop_tx, push_tx, stall, push_rx, pop_rx, nw, nr;
        logic [DATA_W-1:0] wd, od;
        tx_n    = txq.size();
        rx_n    = rxq.size();
        wd      = sw_wdata;
        od      = hw_out_data;
        pop_tx  = (tx_n > 0) && hw_in_ready;
        push_tx = to_sw_sig[0] && !w_busy && (tx_n < DEPTH);
        stall   = to_sw_sig[0] && !w_busy && (tx_n == DEPTH);
        push_rx = hw_out_valid && rdy_en && (rx_n < DEPTH);
        pop_rx  = to_sw_sig[1] && !r_busy && (rx_n > 0);
        nw      = w_busy ? to_sw_sig[0] : push_tx;
        nr      = r_busy ? to_sw_sig[1] : pop_rx;
        @(posedge clk_clk);
        #1;
        if (pop_tx)  void'(txq.pop_front());
        if (push_tx) txq.push_back(wd);
        if (pop_rx)  m_rdata = rxq.pop_front();
        if (push_rx) rxq.push_back(od);
        if (stall && m_stall < 65535) m_stall++;
        w_busy = nw;
        r_busy = nr;
        rdy_en = 1'b1;
        checkOutput();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic modelReset();
        txq.delete();
        rxq.delete();
        w_busy  = 1'b0;
        r_busy  = 1'b0;
        rdy_en  = 1'b0;
        m_rdata = '0;
        m_stall = 0;
    endtask

    task automatic swWrite(input logic [DATA_W-1:0] data, input logic in_rdy);
        applyStimulus(2'b01, data, in_rdy, 1'b0, '0);
        cycle();
        applyStimulus(2'b00, data, in_rdy, 1'b0, '0);
        cycle();
    endtask

    initial begin
        modelReset();
        reset_reset_n = 1'b0;
        applyStimulus(2'b00, '0, 1'b0, 1'b0, '0);
        #12;
        checkOutput();
        checkVal("reset_sw_rdata", 64'(sw_rdata), 64'h0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cycle();
        checkVal("ready_after_release", 64'(hw_out_ready), 64'h1);

        // Single write reaches the accelerator stream.
        applyStimulus(2'b01, 32'hDEADBEEF, 1'b1, 1'b0, '0);
        cycle();
        checkVal("deadbeef_ack", 64'(to_hw_sig[0]), 64'h1);
        checkVal("deadbeef_valid", 64'(hw_in_valid), 64'h1);
        checkVal("deadbeef_data", 64'(hw_in_data), 64'hDEADBEEF);
        applyStimulus(2'b00, 32'h0, 1'b1, 1'b0, '0);
        cycle();
        checkVal("deadbeef_ack_clear", 64'(to_hw_sig[0]), 64'h0);
        cycles(2);

        // Nine writes into a stalled TX FIFO: ninth waits until a pop frees room.
        for (int i = 0; i < 8; i++) swWrite($urandom, 1'b0);
        applyStimulus(2'b01, 32'h99, 1'b0, 1'b0, '0);
        cycles(3);
        checkVal("ninth_ack_low", 64'(to_hw_sig[0]), 64'h0);
        hw_in_ready = 1'b1;
        cycle();
        checkVal("full_push_blocked", 64'(to_hw_sig[0]), 64'h0);
        cycle();
        checkVal("ninth_acked", 64'(to_hw_sig[0]), 64'h1);
        applyStimulus(2'b00, '0, 1'b1, 1'b0, '0);
        cycles(10);
        checkVal("tx_drained", 64'(hw_in_valid), 64'h0);

        // Accelerator returns 1,2,3; software reads them back in order.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(2'b00, '0, 1'b0, 1'b1, DATA_W'(i));
            cycle();
        end
        applyStimulus(2'b00, '0, 1'b0, 1'b0, '0);
        for (int i = 1; i <= 3; i++) begin
            to_sw_sig = 2'b10;
            cycle();
            checkVal("rd_order", 64'(sw_rdata), 64'(i));
            checkVal("rd_ack", 64'(to_hw_sig[1]), 64'h1);
            to_sw_sig = 2'b00;
            cycle();
        end
        to_sw_sig = 2'b10;
        cycles(3);
        checkVal("empty_read_no_ack", 64'(to_hw_sig[1]), 64'h0);
        checkVal("rdata_held", 64'(sw_rdata), 64'h3);
        to_sw_sig = 2'b00;
        cycle();

        // Simultaneous push and pop at TX level 4.
        for (int i = 0; i < 4; i++) swWrite($urandom, 1'b0);
        applyStimulus(2'b01, $urandom, 1'b1, 1'b0, '0);
        cycle();
        applyStimulus(2'b00, '0, 1'b0, 1'b0, '0);
        cycle();
        checkVal("level4_count", 64'(txq.size()), 64'h4);
        hw_in_ready = 1'b1;
        cycles(6);

        // Write and read handshakes completing in the same cycle.
        applyStimulus(2'b00, '0, 1'b0, 1'b1, 32'hA5A5_0001);
        cycle();
        applyStimulus(2'b11, 32'h1234_5678, 1'b0, 1'b0, '0);
        cycle();
        checkVal("both_ack", 64'(to_hw_sig), 64'h3);
        applyStimulus(2'b00, '0, 1'b1, 1'b0, '0);
        cycles(3);

        // Random traffic scored against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom);
            cycle();
        end
        applyStimulus(2'b00, '0, 1'b0, 1'b0, '0);
        cycles(2);
        to_sw_sig = 2'b10;
        cycles(2);
        to_sw_sig = 2'b00;
        cycles(2);
        hw_in_ready = 1'b1;
        cycles(10);

        // Asynchronous reset with a write ack high and three words queued.
        hw_in_ready = 1'b0;
        swWrite(32'h11, 1'b0);
        swWrite(32'h22, 1'b0);
        applyStimulus(2'b01, 32'h33, 1'b0, 1'b0, '0);
        cycle();
        checkVal("pre_reset_ack", 64'(to_hw_sig[0]), 64'h1);
        checkVal("pre_reset_level", 64'(txq.size()), 64'h3);
        #2;
        reset_reset_n = 1'b0;
        modelReset();
        #1;
        checkVal("async_to_hw_sig", 64'(to_hw_sig), 64'h0);
        checkVal("async_in_valid", 64'(hw_in_valid), 64'h0);
        checkVal("async_out_ready", 64'(hw_out_ready), 64'h0);
        checkOutput();
        to_sw_sig = 2'b00;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        cycle();
        swWrite(32'hCAFE_F00D, 1'b0);
        checkVal("post_reset_data", 64'(hw_in_data), 64'hCAFEF00D);
        hw_in_ready = 1'b1;
        cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
